// File: rtl/imm_ext_stage.sv
// Immediate-extension stage for the 16-bit CPU decode path.
// Picks the immediate field for each opcode and sign- or zero-extends it to XLEN.
// An EXT prefix (op 4'b1000) supplies 12 upper bits to the next immediate-bearing
// instruction. One register stage with a valid/ready handshake on both sides.
module imm_ext_stage #(
    parameter int XLEN       = 16,
    parameter bit ZEXT_LOGIC = 1'b0,
    parameter bit PREFIX_EN  = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [15:0]     in_instr,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_imm,
    output logic            out_has_imm,
    output logic            out_is_pfx,
    output logic            out_pfx_used,
    output logic            out_pfx_err
);

    logic            outValid_q, outValid_d;
    logic [XLEN-1:0] outImm_q, outImm_d;
    logic            outHasImm_q, outHasImm_d;
    logic            outIsPfx_q, outIsPfx_d;
    logic            outPfxUsed_q, outPfxUsed_d;
    logic            outPfxErr_q, outPfxErr_d;
    logic            pfxPending_q, pfxPending_d;
    logic [11:0]     pfxBits_q, pfxBits_d;

    logic [3:0]      opcode;
    logic [7:0]      field;
    logic            fieldWide;
    logic            carriesImm;
    logic            isExt;
    logic            zeroExt;
    logic            accept;
    logic [XLEN-1:0] extImm;

    assign opcode = in_instr[3:0];

    // A flush cycle never takes a new word, so the redirect cannot be overtaken.
    assign in_ready = (!outValid_q || out_ready) && !flush;
    assign accept   = in_valid && in_ready;

    // Opcode decode: which bits hold the immediate, how wide it is, and whether it is a prefix.
    always_comb begin
        field      = 8'h00;
        fieldWide  = 1'b0;
        carriesImm = 1'b0;
        isExt      = 1'b0;
        case (opcode)
            4'b0000: begin
                field      = in_instr[15:8];
                fieldWide  = 1'b1;
                carriesImm = 1'b1;
            end
            4'b0001, 4'b0100, 4'b0101,
            4'b1100, 4'b1101, 4'b1110, 4'b1111: begin
                field      = {4'b0000, in_instr[15:12]};
                carriesImm = 1'b1;
            end
            4'b0010, 4'b0011, 4'b0110, 4'b0111: begin
                field      = {4'b0000, in_instr[7:4]};
                carriesImm = 1'b1;
            end
            4'b1000: begin
                isExt = PREFIX_EN;
            end
            default: begin
                carriesImm = 1'b0;
            end
        endcase
        zeroExt = ZEXT_LOGIC && (opcode == 4'b1110 || opcode == 4'b1111);
    end

    // Extension: the prefix bits sit above the field; the result is cast to XLEN,
    // which sign/zero-extends short values and keeps only the low XLEN bits of long ones.
    always_comb begin
        extImm = '0;
        case ({pfxPending_q, fieldWide})
            2'b11: begin
                if (zeroExt) extImm = XLEN'({pfxBits_q, field});
                else         extImm = XLEN'($signed({pfxBits_q, field}));
            end
            2'b10: begin
                if (zeroExt) extImm = XLEN'({pfxBits_q, field[3:0]});
                else         extImm = XLEN'($signed({pfxBits_q, field[3:0]}));
            end
            2'b01: begin
                if (zeroExt) extImm = XLEN'(field);
                else         extImm = XLEN'($signed(field));
            end
            default: begin
                if (zeroExt) extImm = XLEN'(field[3:0]);
                else         extImm = XLEN'($signed(field[3:0]));
            end
        endcase
    end

    // Next-state: load a fresh result on accept, drain on downstream take, kill everything on flush.
    always_comb begin
        outValid_d   = outValid_q;
        outImm_d     = outImm_q;
        outHasImm_d  = outHasImm_q;
        outIsPfx_d   = outIsPfx_q;
        outPfxUsed_d = outPfxUsed_q;
        outPfxErr_d  = outPfxErr_q;
        pfxPending_d = pfxPending_q;
        pfxBits_d    = pfxBits_q;
        if (accept) begin
            outValid_d   = 1'b1;
            outIsPfx_d   = 1'b0;
            outPfxUsed_d = 1'b0;
            outPfxErr_d  = 1'b0;
            if (isExt) begin
                pfxBits_d    = in_instr[15:4];
                pfxPending_d = 1'b1;
                outIsPfx_d   = 1'b1;
                outImm_d     = '0;
                outHasImm_d  = 1'b0;
            end else if (carriesImm) begin
                outImm_d     = extImm;
                outHasImm_d  = 1'b1;
                outPfxUsed_d = pfxPending_q;
                pfxPending_d = 1'b0;
            end else begin
                outPfxErr_d  = pfxPending_q;
                pfxPending_d = 1'b0;
                outImm_d     = '0;
                outHasImm_d  = 1'b0;
            end
        end else if (out_ready) begin
            outValid_d = 1'b0;
        end
        if (flush) begin
            outValid_d   = 1'b0;
            pfxPending_d = 1'b0;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            outValid_q   <= 1'b0;
            outImm_q     <= '0;
            outHasImm_q  <= 1'b0;
            outIsPfx_q   <= 1'b0;
            outPfxUsed_q <= 1'b0;
            outPfxErr_q  <= 1'b0;
            pfxPending_q <= 1'b0;
            pfxBits_q    <= 12'h000;
        end else begin
            outValid_q   <= outValid_d;
            outImm_q     <= outImm_d;
            outHasImm_q  <= outHasImm_d;
            outIsPfx_q   <= outIsPfx_d;
            outPfxUsed_q <= outPfxUsed_d;
            outPfxErr_q  <= outPfxErr_d;
            pfxPending_q <= pfxPending_d;
            pfxBits_q    <= pfxBits_d;
        end
    end

    assign out_valid    = outValid_q;
    assign out_imm      = outImm_q;
    assign out_has_imm  = outHasImm_q;
    assign out_is_pfx   = outIsPfx_q;
    assign out_pfx_used = outPfxUsed_q;
    assign out_pfx_err  = outPfxErr_q;

endmodule

// File: tb/tb_imm_ext_stage.sv
// Bench for imm_ext_stage: three configurations driven by the same directed stream,
// an arithmetic reference model checked on every cycle, and literal spot checks.
module tb_imm_ext_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic [15:0] in_instr;
    logic        out_ready;

    logic        validA, readyA, hasA, pfxA, usedA, errA;
    logic [15:0] immA;
    logic        validZ, readyZ, hasZ, pfxZ, usedZ, errZ;
    logic [31:0] immZ;
    logic        validN, readyN, hasN, pfxN, usedN, errN;
    logic [15:0] immN;

    int passCount  = 0;
    int checkCount = 0;
    bit started    = 1'b0;

    // Configuration table: index 0 = default, 1 = XLEN 32 with logic zero-extension, 2 = prefix disabled.
    int cfgXlen[3]  = '{16, 32, 16};
    bit cfgZext[3]  = '{1'b0, 1'b1, 1'b0};
    bit cfgPfxEn[3] = '{1'b1, 1'b1, 1'b0};
    string cfgTag[3] = '{"dflt", "zx32", "nopfx"};

    bit     mValid[3];
    longint mImm[3];
    bit     mHas[3];
    bit     mIsPfx[3];
    bit     mUsed[3];
    bit     mErr[3];
    bit     mPend[3];
    longint mPfx[3];

    imm_ext_stage #(.XLEN(16), .ZEXT_LOGIC(1'b0), .PREFIX_EN(1'b1)) dutA (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(readyA),
        .in_instr(in_instr), .out_valid(validA), .out_ready(out_ready), .out_imm(immA),
        .out_has_imm(hasA), .out_is_pfx(pfxA), .out_pfx_used(usedA), .out_pfx_err(errA));

    imm_ext_stage #(.XLEN(32), .ZEXT_LOGIC(1'b1), .PREFIX_EN(1'b1)) dutZ (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(readyZ),
        .in_instr(in_instr), .out_valid(validZ), .out_ready(out_ready), .out_imm(immZ),
        .out_has_imm(hasZ), .out_is_pfx(pfxZ), .out_pfx_used(usedZ), .out_pfx_err(errZ));

    imm_ext_stage #(.XLEN(16), .ZEXT_LOGIC(1'b0), .PREFIX_EN(1'b0)) dutN (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(readyN),
        .in_instr(in_instr), .out_valid(validN), .out_ready(out_ready), .out_imm(immN),
        .out_has_imm(hasN), .out_is_pfx(pfxN), .out_pfx_used(usedN), .out_pfx_err(errN));

    always #5 clk = ~clk;

    // Numeric value of an n-bit pattern under sign or zero interpretation, reduced mod 2^xlen.
    function automatic longint extModel(input longint raw, input int n, input bit zext, input int xlen);
        longint v;
        v = raw;
        if (!zext && v >= (longint'(1) << (n - 1)))
            v = v - (longint'(1) << n);
        return v & ((longint'(1) << xlen) - 1);
    endfunction

    // Opcode table: kind 0 = no immediate, 1 = immediate of width w, 2 = prefix.
    function automatic void decodeModel(input logic [15:0] ins, input bit pfxEn,
                                        output int kind, output int w, output longint fld);
        int op;
        op   = int'(ins & 16'h000F);
        kind = 1;
        w    = 4;
        fld  = 0;
        case (op)
            0:                 begin w = 8; fld = longint'((ins >> 8) & 16'h00FF); end
            1, 4, 5, 12, 13, 14, 15: fld = longint'((ins >> 12) & 16'h000F);
            2, 3, 6, 7:        fld = longint'((ins >> 4) & 16'h000F);
            8:                 kind = pfxEn ? 2 : 0;
            default:           kind = 0;
        endcase
    endfunction

    task automatic modelStep();
        int kind, w, op;
        longint fld;
        bit rdy, zx;
        for (int c = 0; c < 3; c++) begin
            if (!rst_n) begin
                mValid[c] = 0; mImm[c] = 0; mHas[c] = 0; mIsPfx[c] = 0;
                mUsed[c] = 0; mErr[c] = 0; mPend[c] = 0; mPfx[c] = 0;
            end else if (flush) begin
                mValid[c] = 0;
                mPend[c]  = 0;
            end else begin
                rdy = !mValid[c] || out_ready;
                if (in_valid && rdy) begin
                    decodeModel(in_instr, cfgPfxEn[c], kind, w, fld);
                    op = int'(in_instr & 16'h000F);
                    zx = cfgZext[c] && (op == 14 || op == 15);
                    mValid[c] = 1; mIsPfx[c] = 0; mUsed[c] = 0; mErr[c] = 0;
                    if (kind == 2) begin
                        mPfx[c] = longint'(in_instr >> 4);
                        mPend[c] = 1; mIsPfx[c] = 1; mImm[c] = 0; mHas[c] = 0;
                    end else if (kind == 1) begin
                        if (mPend[c])
                            mImm[c] = extModel(mPfx[c] * (longint'(1) << w) + fld, 12 + w, zx, cfgXlen[c]);
                        else
                            mImm[c] = extModel(fld, w, zx, cfgXlen[c]);
                        mHas[c] = 1; mUsed[c] = mPend[c]; mPend[c] = 0;
                    end else begin
                        mErr[c] = mPend[c]; mPend[c] = 0; mImm[c] = 0; mHas[c] = 0;
                    end
                end else if (out_ready) begin
                    mValid[c] = 0;
                end
            end
        end
    endtask

    task automatic check(input string name, input longint act, input longint exp);
        checkCount++;
        if (act == exp) passCount++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic compareCfg(input int c, input logic v, input logic r, input longint imm,
                              input logic h, input logic p, input logic u, input logic e);
        check({cfgTag[c], " out_valid"}, longint'(v), longint'(mValid[c]));
        check({cfgTag[c], " in_ready"}, longint'(r), longint'((!mValid[c] || out_ready) && !flush));
        if (mValid[c]) begin
            check({cfgTag[c], " out_imm"}, imm, mImm[c]);
            check({cfgTag[c], " out_has_imm"}, longint'(h), longint'(mHas[c]));
            check({cfgTag[c], " out_is_pfx"}, longint'(p), longint'(mIsPfx[c]));
            check({cfgTag[c], " out_pfx_used"}, longint'(u), longint'(mUsed[c]));
            check({cfgTag[c], " out_pfx_err"}, longint'(e), longint'(mErr[c]));
        end
    endtask

    task automatic checkOutput();
        compareCfg(0, validA, readyA, longint'(immA), hasA, pfxA, usedA, errA);
        compareCfg(1, validZ, readyZ, longint'(immZ), hasZ, pfxZ, usedZ, errZ);
        compareCfg(2, validN, readyN, longint'(immN), hasN, pfxN, usedN, errN);
    endtask

    always @(posedge clk) modelStep();

    always @(negedge clk) if (started) checkOutput();

    // Holds the given inputs across one rising edge; returns 2 time units after it.
    task automatic applyStimulus(input logic v, input logic [15:0] ins, input logic rdy, input logic fl);
        in_valid  = v;
        in_instr  = ins;
        out_ready = rdy;
        flush     = fl;
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst_n = 1'b0;
        applyStimulus(1'b1, 16'hF00C, 1'b1, 1'b0);
        started = 1'b1;
        applyStimulus(1'b1, 16'hF00C, 1'b1, 1'b0);
        check("reset out_valid", longint'(validA), 0);
        check("reset out_imm", longint'(immA), 0);
        check("reset flags", longint'({hasA, pfxA, usedA, errA}), 0);
        rst_n = 1'b1;
        applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0);
        check("post-reset out_valid", longint'(validA), 0);

        applyStimulus(1'b1, 16'hF00C, 1'b1, 1'b0);
        check("addi F00C imm", longint'(immA), 64'hFFFF);
        check("addi F00C has_imm", longint'(hasA), 1);
        check("addi F00C no prefix after reset", longint'(usedA), 0);
        check("addi F00C imm x32", longint'(immZ), 64'hFFFFFFFF);
        applyStimulus(1'b1, 16'h0500, 1'b1, 1'b0);
        check("jal 0500 imm", longint'(immA), 64'h0005);
        applyStimulus(1'b1, 16'h8000, 1'b1, 1'b0);
        check("jal 8000 imm", longint'(immA), 64'hFF80);
        applyStimulus(1'b1, 16'h00F6, 1'b1, 1'b0);
        check("sb 00F6 imm", longint'(immA), 64'hFFFF);

        applyStimulus(1'b1, 16'h1238, 1'b1, 1'b0);
        check("EXT 1238 is_pfx", longint'(pfxA), 1);
        check("EXT 1238 imm", longint'(immA), 0);
        check("EXT nopfx is_pfx", longint'(pfxN), 0);
        applyStimulus(1'b1, 16'h400C, 1'b1, 1'b0);
        check("EXT+addi imm", longint'(immA), 64'h1234);
        check("EXT+addi pfx_used", longint'(usedA), 1);
        check("nopfx addi imm", longint'(immN), 64'h0004);

        applyStimulus(1'b1, 16'h800F, 1'b1, 1'b0);
        check("ori sext imm", longint'(immA), 64'hFFF8);
        check("ori zext imm", longint'(immZ), 64'h00000008);

        applyStimulus(1'b1, 16'h7005, 1'b1, 1'b0);
        check("lw 7005 imm", longint'(immA), 64'h0007);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 16'h9005, 1'b0, 1'b0);
            check("stall imm hold", longint'(immA), 64'h0007);
            check("stall in_ready", longint'(readyA), 0);
            check("stall out_valid", longint'(validA), 1);
        end
        applyStimulus(1'b1, 16'h9005, 1'b1, 1'b0);
        check("release lw 9005 imm", longint'(immA), 64'hFFF9);

        applyStimulus(1'b1, 16'hFFF8, 1'b1, 1'b0);
        applyStimulus(1'b1, 16'h100C, 1'b1, 1'b1);
        check("flush out_valid", longint'(validA), 0);
        applyStimulus(1'b1, 16'h100C, 1'b1, 1'b0);
        check("post-flush addi imm", longint'(immA), 64'h0001);
        check("post-flush pfx_used", longint'(usedA), 0);

        applyStimulus(1'b1, 16'h0018, 1'b1, 1'b0);
        applyStimulus(1'b1, 16'h0009, 1'b1, 1'b0);
        check("EXT+noimm pfx_err", longint'(errA), 1);
        check("EXT+noimm imm", longint'(immA), 0);
        check("nopfx noimm pfx_err", longint'(errN), 0);
        applyStimulus(1'b1, 16'h100C, 1'b1, 1'b0);
        check("after err addi imm", longint'(immA), 64'h0001);
        check("after err pfx_used", longint'(usedA), 0);

        applyStimulus(1'b1, 16'hABC8, 1'b1, 1'b0);
        applyStimulus(1'b1, 16'h1200, 1'b1, 1'b0);
        check("EXT+jal truncated", longint'(immA), 64'hBC12);
        check("EXT+jal x32", longint'(immZ), 64'hFFFABC12);

        applyStimulus(1'b1, 16'h0018, 1'b1, 1'b0);
        applyStimulus(1'b1, 16'h0028, 1'b1, 1'b0);
        check("EXT overwrite no err", longint'(errA), 0);
        applyStimulus(1'b1, 16'h0032, 1'b1, 1'b0);
        check("EXT overwrite beq imm", longint'(immA), 64'h0023);

        applyStimulus(1'b1, 16'hFFF8, 1'b1, 1'b0);
        applyStimulus(1'b1, 16'hF00F, 1'b1, 1'b0);
        check("EXT+ori sext", longint'(immA), 64'hFFFF);
        check("EXT+ori zext x32", longint'(immZ), 64'h0000FFFF);

        applyStimulus(1'b1, 16'h300E, 1'b1, 1'b0);
        applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0);
        check("drain out_valid", longint'(validA), 0);
        applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
